// File: rtl/dcache_dma_mover.sv
// Tile DMA mover between external memory and the dcache DMA port.
// Load moves memory elements into a dcache slot; store moves slot elements out to memory.
// Store reads go through a 2-entry FIFO that absorbs the dcache's one-cycle read latency.
module dcache_dma_mover #(
  parameter int BITS   = 18,
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_store,
  input  logic [1:0]        cmd_slot,
  input  logic [10:0]       cmd_cache_addr,
  input  logic [ADDR_W-1:0] cmd_mem_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [BITS-1:0]   mem_req_dat_w,
  input  logic              mem_rsp_valid,
  input  logic [BITS-1:0]   mem_rsp_dat,
  output logic [1:0]        dma_slot,
  output logic [10:0]       dma_addr,
  output logic              dma_we,
  output logic [BITS-1:0]   dma_dat_w,
  output logic              dma_re,
  input  logic [BITS-1:0]   dma_dat_r
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          slot_q, slot_d;
  logic [10:0]         cache_base_q, cache_base_d;
  logic [ADDR_W-1:0]   mem_base_q, mem_base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  // issue: load requests sent / store dcache reads issued
  // retire: load responses written / store memory writes accepted
  logic [LEN_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]    retire_cnt_q, retire_cnt_d;
  logic                inflight_q, inflight_d;
  logic [BITS-1:0]     fifo_q [2];
  logic [BITS-1:0]     fifo_d [2];
  logic                fifo_wr_ptr_q, fifo_wr_ptr_d;
  logic                fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic [1:0]          fifo_occ_q, fifo_occ_d;
  logic                dma_we_q, dma_we_d;
  logic [10:0]         dma_addr_q, dma_addr_d;
  logic [BITS-1:0]     dma_dat_w_q, dma_dat_w_d;
  logic                done_q, done_d;

  logic                req_fire;
  logic [2:0]          credit_level;

  // Output decode and the store read-credit rule
  always_comb begin
    cmd_ready     = (state_q == IDLE);
    busy          = (state_q != IDLE);
    done          = done_q;
    mem_req_valid = ((state_q == LOAD) && (issue_cnt_q < len_q)) ||
                    ((state_q == STORE) && (fifo_occ_q != 2'd0));
    mem_req_we    = (state_q == STORE);
    mem_req_addr  = mem_base_q + ADDR_W'((state_q == STORE) ? retire_cnt_q : issue_cnt_q);
    mem_req_dat_w = fifo_q[fifo_rd_ptr_q];
    req_fire      = mem_req_valid && mem_req_ready;
    // Occupancy the FIFO will have once the outstanding read lands and this cycle's pop retires
    credit_level  = {1'b0, fifo_occ_q} + {2'b00, inflight_q} - {2'b00, req_fire};
    dma_re        = (state_q == STORE) && (issue_cnt_q < len_q) && (credit_level < 3'd2);
    dma_slot      = slot_q;
    dma_addr      = (state_q == STORE) ? (cache_base_q + 11'(issue_cnt_q)) : dma_addr_q;
    dma_we        = dma_we_q;
    dma_dat_w     = dma_dat_w_q;
  end

  // Next-state logic for the FSM, counters, FIFO and registered dcache write port
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    cache_base_d  = cache_base_q;
    mem_base_d    = mem_base_q;
    len_d         = len_q;
    issue_cnt_d   = issue_cnt_q;
    retire_cnt_d  = retire_cnt_q;
    inflight_d    = dma_re;
    fifo_d        = fifo_q;
    fifo_wr_ptr_d = fifo_wr_ptr_q;
    fifo_rd_ptr_d = fifo_rd_ptr_q;
    fifo_occ_d    = fifo_occ_q;
    dma_we_d      = 1'b0;
    dma_addr_d    = dma_addr_q;
    dma_dat_w_d   = dma_dat_w_q;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          slot_d       = cmd_slot;
          cache_base_d = cmd_cache_addr;
          mem_base_d   = cmd_mem_addr;
          len_d        = cmd_len;
          issue_cnt_d  = '0;
          retire_cnt_d = '0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else if (cmd_store) begin
            state_d = STORE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (req_fire) begin
          issue_cnt_d = issue_cnt_q + LEN_W'(1);
        end
        if (mem_rsp_valid && (retire_cnt_q < len_q)) begin
          dma_we_d     = 1'b1;
          dma_addr_d   = cache_base_q + 11'(retire_cnt_q);
          dma_dat_w_d  = mem_rsp_dat;
          retire_cnt_d = retire_cnt_q + LEN_W'(1);
          if (retire_cnt_q + LEN_W'(1) == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      STORE: begin
        if (dma_re) begin
          issue_cnt_d = issue_cnt_q + LEN_W'(1);
        end
        if (inflight_q) begin
          fifo_d[fifo_wr_ptr_q] = dma_dat_r;
          fifo_wr_ptr_d         = ~fifo_wr_ptr_q;
        end
        if (req_fire) begin
          fifo_rd_ptr_d = ~fifo_rd_ptr_q;
          retire_cnt_d  = retire_cnt_q + LEN_W'(1);
          if (retire_cnt_q + LEN_W'(1) == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        fifo_occ_d = fifo_occ_q + {1'b0, inflight_q} - {1'b0, req_fire};
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any transfer in flight without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      cache_base_q  <= '0;
      mem_base_q    <= '0;
      len_q         <= '0;
      issue_cnt_q   <= '0;
      retire_cnt_q  <= '0;
      inflight_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_occ_q    <= '0;
      dma_we_q      <= 1'b0;
      dma_addr_q    <= '0;
      dma_dat_w_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      cache_base_q  <= cache_base_d;
      mem_base_q    <= mem_base_d;
      len_q         <= len_d;
      issue_cnt_q   <= issue_cnt_d;
      retire_cnt_q  <= retire_cnt_d;
      inflight_q    <= inflight_d;
      fifo_q        <= fifo_d;
      fifo_wr_ptr_q <= fifo_wr_ptr_d;
      fifo_rd_ptr_q <= fifo_rd_ptr_d;
      fifo_occ_q    <= fifo_occ_d;
      dma_we_q      <= dma_we_d;
      dma_addr_q    <= dma_addr_d;
      dma_dat_w_q   <= dma_dat_w_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_dcache_dma_mover.sv
// Scoreboard bench for dcache_dma_mover: directed commands push expected dcache writes,
// memory writes and done pulses into queues; a negedge monitor pops and compares.
module tb_dcache_dma_mover;

  localparam int BITS   = 18;
  localparam int ADDR_W = 24;
  localparam int LEN_W  = 11;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_store;
  logic [1:0]        cmd_slot;
  logic [10:0]       cmd_cache_addr;
  logic [ADDR_W-1:0] cmd_mem_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              busy;
  logic              done;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [BITS-1:0]   mem_req_dat_w;
  logic              mem_rsp_valid;
  logic [BITS-1:0]   mem_rsp_dat;
  logic [1:0]        dma_slot;
  logic [10:0]       dma_addr;
  logic              dma_we;
  logic [BITS-1:0]   dma_dat_w;
  logic              dma_re;
  logic [BITS-1:0]   dma_dat_r;

  dcache_dma_mover #(.BITS(BITS), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_slot(cmd_slot), .cmd_cache_addr(cmd_cache_addr), .cmd_mem_addr(cmd_mem_addr),
    .cmd_len(cmd_len), .busy(busy), .done(done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_dat_w(mem_req_dat_w),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_dat(mem_rsp_dat),
    .dma_slot(dma_slot), .dma_addr(dma_addr), .dma_we(dma_we), .dma_dat_w(dma_dat_w),
    .dma_re(dma_re), .dma_dat_r(dma_dat_r)
  );

  typedef struct packed {
    logic [1:0]  slot;
    logic [23:0] addr;
    logic [17:0] data;
  } ent_t;

  ent_t exp_dma[$];
  ent_t exp_wr[$];
  int   exp_done[$];   // 0: with last dma_we, 1: cycle after last mem write, 2: cycle after accept

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc_cyc  = -10;
  int last_done_cyc = -10;
  int last_wr_cyc   = -10;
  int first_wr_cyc  = -1;
  int first_wv_cyc  = -1;
  int wr_seen       = 0;
  int done_pulses   = 0;

  logic [17:0] ext_mem [int];
  logic [17:0] cache_mem [4][2048];

  logic        ready_mode;
  logic [1:0]  rdy_ph;
  logic        p0_v, p1_v;
  logic [17:0] p0_d, p1_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] mem_rd(input logic [23:0] a);
    if (ext_mem.exists(int'(a))) return ext_mem[int'(a)];
    return 18'h3FFFF;
  endfunction

  // External memory: ready pattern 1,0,0 repeating when ready_mode=1; reads return 2 cycles after handshake
  assign mem_req_ready = !ready_mode || (rdy_ph == 2'd0);
  assign mem_rsp_valid = p1_v;
  assign mem_rsp_dat   = p1_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_v <= 1'b0; p1_v <= 1'b0; p0_d <= '0; p1_d <= '0; rdy_ph <= 2'd0;
    end else begin
      rdy_ph <= (rdy_ph == 2'd2) ? 2'd0 : rdy_ph + 2'd1;
      p1_v   <= p0_v;
      p1_d   <= p0_d;
      p0_v   <= mem_req_valid && mem_req_ready && !mem_req_we;
      p0_d   <= mem_rd(mem_req_addr);
    end
  end

  // dcache model: registered read port
  always @(posedge clk) begin
    if (dma_re) dma_dat_r <= cache_mem[dma_slot][dma_addr];
  end

  // Monitor: pops scoreboard queues whenever the DUT presents an output event
  logic        stall_prev;
  logic [23:0] s_addr;
  logic [17:0] s_dat;
  logic        s_we;
  initial begin
    ent_t e;
    int   k;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (dma_we || dma_re) begin
          total++;
          if (dma_we && dma_re) begin
            bad++;
            $display("FAIL we_re_exclusive cyc=%0d dma_we=%b dma_re=%b, required not both", cyc, dma_we, dma_re);
          end
        end
        if (dma_we) begin
          total++;
          if (exp_dma.size() == 0) begin
            bad++;
            $display("FAIL dma_write unexpected slot=%0d addr=%h data=%h, required none", dma_slot, dma_addr, dma_dat_w);
          end else begin
            e = exp_dma.pop_front();
            if (dma_slot != e.slot || dma_addr != e.addr[10:0] || dma_dat_w != e.data) begin
              bad++;
              $display("FAIL dma_write got slot=%0d addr=%h data=%h, required slot=%0d addr=%h data=%h",
                       dma_slot, dma_addr, dma_dat_w, e.slot, e.addr[10:0], e.data);
            end else begin
              $display("dma write cyc=%0d slot=%0d addr=%h data=%h ok", cyc, dma_slot, dma_addr, dma_dat_w);
            end
          end
        end
        if (stall_prev) begin
          total++;
          if (!mem_req_valid || mem_req_addr != s_addr || mem_req_dat_w != s_dat || mem_req_we != s_we) begin
            bad++;
            $display("FAIL req_stable got v=%b we=%b addr=%h dat=%h, required v=1 we=%b addr=%h dat=%h",
                     mem_req_valid, mem_req_we, mem_req_addr, mem_req_dat_w, s_we, s_addr, s_dat);
          end
        end
        stall_prev = mem_req_valid && !mem_req_ready;
        s_addr = mem_req_addr; s_dat = mem_req_dat_w; s_we = mem_req_we;
        if (mem_req_valid && mem_req_we && first_wv_cyc < 0) first_wv_cyc = cyc;
        if (mem_req_valid && mem_req_ready && mem_req_we) begin
          total++;
          wr_seen++;
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
          last_wr_cyc = cyc;
          if (exp_wr.size() == 0) begin
            bad++;
            $display("FAIL mem_write unexpected addr=%h data=%h, required none", mem_req_addr, mem_req_dat_w);
          end else begin
            e = exp_wr.pop_front();
            if (mem_req_addr != e.addr || mem_req_dat_w != e.data) begin
              bad++;
              $display("FAIL mem_write got addr=%h data=%h, required addr=%h data=%h",
                       mem_req_addr, mem_req_dat_w, e.addr, e.data);
            end else begin
              $display("mem write cyc=%0d addr=%h data=%h ok", cyc, mem_req_addr, mem_req_dat_w);
            end
          end
        end
        if (done) begin
          total++;
          done_pulses++;
          if (exp_done.size() == 0) begin
            bad++;
            $display("FAIL done unexpected at cyc=%0d, required no pulse", cyc);
          end else begin
            k = exp_done.pop_front();
            if ((k == 0 && !(dma_we && exp_dma.size() == 0)) ||
                (k == 1 && !(cyc == last_wr_cyc + 1 && exp_wr.size() == 0)) ||
                (k == 2 && cyc != last_acc_cyc)) begin
              bad++;
              $display("FAIL done_timing kind=%0d got cyc=%0d dma_we=%b last_wr=%0d acc=%0d, required matching cycle",
                       k, cyc, dma_we, last_wr_cyc, last_acc_cyc);
            end else begin
              $display("done cyc=%0d kind=%0d ok", cyc, k);
            end
          end
          last_done_cyc = cyc;
        end
      end
    end
  end

  task automatic send_cmd(input logic st, input logic [1:0] sl, input logic [10:0] ca,
                          input logic [23:0] ma, input logic [10:0] ln);
    int n;
    n = 0;
    @(negedge clk); #1;
    cmd_store = st; cmd_slot = sl; cmd_cache_addr = ca; cmd_mem_addr = ma; cmd_len = ln;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL cmd_accept timeout cmd_ready=%b, required 1", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      last_acc_cyc = cyc;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_all(input string name);
    int n;
    n = 0;
    while ((exp_dma.size() + exp_wr.size() + exp_done.size()) != 0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s drain got pending dma=%0d wr=%0d done=%0d, required 0",
               name, exp_dma.size(), exp_wr.size(), exp_done.size());
      exp_dma.delete(); exp_wr.delete(); exp_done.delete();
    end
  endtask

  task automatic push_dma(input logic [1:0] sl, input logic [10:0] a, input logic [17:0] d);
    exp_dma.push_back({sl, 13'd0, a, d});
  endtask

  task automatic push_wr(input logic [23:0] a, input logic [17:0] d);
    exp_wr.push_back({2'd0, a, d});
  endtask

  task automatic check_reset_outputs(input string name);
    logic [78:0] v;
    v = {busy, done, mem_req_valid, mem_req_we, mem_req_addr, mem_req_dat_w,
         dma_slot, dma_addr, dma_we, dma_dat_w, dma_re};
    total++;
    if (v != '0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s outputs=%h cmd_ready=%b, required outputs=0 cmd_ready=1", name, v, cmd_ready);
    end
  endtask

  // Watchdog
  initial begin
    #300000;
    bad++;
    $display("FAIL watchdog expired at cyc=%0d, required completion", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int snap;
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_slot = 2'd0;
    cmd_cache_addr = '0; cmd_mem_addr = '0; cmd_len = '0; ready_mode = 1'b0;
    for (int s = 0; s < 4; s++) for (int a = 0; a < 2048; a++) cache_mem[s][a] = 18'h15A5A;
    for (int i = 0; i < 16; i++) cache_mem[2][32 + i] = 18'(i);          // 0x20..0x2F = 0..15
    for (int i = 0; i < 8; i++)  cache_mem[1][64 + i] = 18'(256 + i);    // 0x40.. = 0x100..
    for (int i = 0; i < 8; i++)  cache_mem[1][96 + i] = 18'(768 + i);    // 0x60.. = 0x300..
    cache_mem[3][128] = 18'h200; cache_mem[3][129] = 18'h201;
    cache_mem[3][130] = 18'h202; cache_mem[3][131] = 18'h203;
    ext_mem[32'h100] = 18'hA; ext_mem[32'h101] = 18'hB;
    ext_mem[32'h102] = 18'hC; ext_mem[32'h103] = 18'hD;
    ext_mem[32'h500] = 18'h1000; ext_mem[32'h501] = 18'h1001;
    ext_mem[32'h502] = 18'h1002; ext_mem[32'h503] = 18'h1003;
    ext_mem[32'h300] = 18'h111; ext_mem[32'h301] = 18'h222; ext_mem[32'h302] = 18'h333;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    // Load len 4 then store len 16 queued behind it (accepted in the load's done cycle)
    push_dma(2'd1, 11'h010, 18'hA); push_dma(2'd1, 11'h011, 18'hB);
    push_dma(2'd1, 11'h012, 18'hC); push_dma(2'd1, 11'h013, 18'hD);
    exp_done.push_back(0);
    first_wv_cyc = -1; first_wr_cyc = -1; wr_seen = 0;
    send_cmd(1'b0, 2'd1, 11'h010, 24'h000100, 11'd4);
    for (int i = 0; i < 16; i++) push_wr(24'h400 + 24'(i), 18'(i));
    exp_done.push_back(1);
    send_cmd(1'b1, 2'd2, 11'h020, 24'h000400, 11'd16);
    total++;
    if (last_acc_cyc != last_done_cyc + 1) begin
      bad++;
      $display("FAIL accept_in_done_cycle got acc=%0d done=%0d, required acc=done+1", last_acc_cyc, last_done_cyc);
    end
    wait_all("load4_store16");
    total++;
    if (first_wv_cyc != last_acc_cyc + 2) begin
      bad++;
      $display("FAIL store_latency got first_valid=%0d, required %0d", first_wv_cyc, last_acc_cyc + 2);
    end
    total++;
    if (wr_seen != 16 || last_wr_cyc - first_wr_cyc != 15) begin
      bad++;
      $display("FAIL store_throughput got writes=%0d span=%0d, required 16 and 15", wr_seen, last_wr_cyc - first_wr_cyc);
    end

    // Store len 8 with ready toggling 1,0,0
    ready_mode = 1'b1; wr_seen = 0;
    for (int i = 0; i < 8; i++) push_wr(24'h800 + 24'(i), 18'(256 + i));
    exp_done.push_back(1);
    send_cmd(1'b1, 2'd1, 11'h040, 24'h000800, 11'd8);
    wait_all("store8_stall");
    total++;
    if (wr_seen != 8) begin
      bad++;
      $display("FAIL store_stall_count got %0d, required 8", wr_seen);
    end
    ready_mode = 1'b0;

    // Cache address wrap on load
    push_dma(2'd0, 11'h7FE, 18'h1000); push_dma(2'd0, 11'h7FF, 18'h1001);
    push_dma(2'd0, 11'h000, 18'h1002); push_dma(2'd0, 11'h001, 18'h1003);
    exp_done.push_back(0);
    send_cmd(1'b0, 2'd0, 11'h7FE, 24'h000500, 11'd4);
    wait_all("load_wrap");

    // Memory address wrap on store
    push_wr(24'hFFFFFE, 18'h200); push_wr(24'hFFFFFF, 18'h201);
    push_wr(24'h000000, 18'h202); push_wr(24'h000001, 18'h203);
    exp_done.push_back(1);
    send_cmd(1'b1, 2'd3, 11'h080, 24'hFFFFFE, 11'd4);
    wait_all("store_wrap");

    // Zero-length command
    exp_done.push_back(2);
    send_cmd(1'b1, 2'd1, 11'h000, 24'h000000, 11'd0);
    repeat (3) begin
      @(negedge clk); #1;
      total++;
      if (busy || mem_req_valid || dma_we || dma_re) begin
        bad++;
        $display("FAIL len0_quiet got busy=%b req=%b we=%b re=%b, required all 0", busy, mem_req_valid, dma_we, dma_re);
      end
    end
    wait_all("len0");

    // Reset in the middle of a store after 3 of 8 writes
    wr_seen = 0;
    for (int i = 0; i < 8; i++) push_wr(24'h900 + 24'(i), 18'(768 + i));
    exp_done.push_back(1);
    send_cmd(1'b1, 2'd1, 11'h060, 24'h000900, 11'd8);
    n = 0;
    while (wr_seen < 3 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    total++;
    if (exp_wr.size() != 5) begin
      bad++;
      $display("FAIL writes_before_reset got pending=%0d, required 5", exp_wr.size());
    end
    exp_wr.delete(); exp_done.delete(); exp_dma.delete();
    snap = done_pulses;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fresh load completes normally after reset
    push_dma(2'd0, 11'h050, 18'h111); push_dma(2'd0, 11'h051, 18'h222); push_dma(2'd0, 11'h052, 18'h333);
    exp_done.push_back(0);
    send_cmd(1'b0, 2'd0, 11'h050, 24'h000300, 11'd3);
    wait_all("load_after_reset");
    repeat (3) @(negedge clk);
    total++;
    if (done_pulses != snap + 1) begin
      bad++;
      $display("FAIL done_count_after_reset got %0d, required %0d", done_pulses - snap, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_dma_mover.md
Name: dcache_dma_mover

Overview:
- Upstream DMA engine feeding the dcache DMA port (dma_slot/dma_addr/dma_we/dma_dat_w/dma_re/dma_dat_r).
- Accepts one tile-transfer command at a time and moves cmd_len elements between external memory and a dcache slot.
- Direction "load" is mem->cache; direction "store" is cache->mem.
- Sits between the instruction decoder's DMA command queue and the dcache; external memory uses a valid/ready request channel and an always-accepted response channel.

Parameters:
BITS, 18, element width; must match the dcache dma_dat_w/dma_dat_r width.
ADDR_W, 24, external memory element address width.
LEN_W, 11, width of the transfer length field.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  high exactly when the FSM is in IDLE.
cmd_store  in  1  1 = cache->mem, 0 = mem->cache.
cmd_slot  in  2  dcache slot; passed through to dma_slot unchanged.
cmd_cache_addr  in  11  first dcache element address.
cmd_mem_addr  in  ADDR_W  first memory element address.
cmd_len  in  LEN_W  element count; 0 = no-op.
busy  out  1  high when the FSM is not in IDLE.
done  out  1  one-cycle completion pulse.
mem_req_valid  out  1  memory request valid.
mem_req_ready  in  1  memory accepts the request.
mem_req_we  out  1  1 = write, 0 = read.
mem_req_addr  out  ADDR_W  request address.
mem_req_dat_w  out  BITS  write data.
mem_rsp_valid  in  1  read data valid; responses return in request order.
mem_rsp_dat  in  BITS  read data.
dma_slot  out  2  to dcache.
dma_addr  out  11  to dcache.
dma_we  out  1  to dcache.
dma_dat_w  out  BITS  to dcache.
dma_re  out  1  to dcache.
dma_dat_r  in  BITS  from dcache; valid the cycle after dma_re (registered read).

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM -> IDLE; all counters and the FIFO cleared.
  - All outputs 0 except cmd_ready = 1.
  - A transfer in progress is abandoned with no done pulse.
  - The memory side is reset together with this block; no stale responses arrive afterwards.
- States: IDLE, LOAD, STORE.
  - Command accepted on cmd_valid & cmd_ready.
  - All cmd_* fields are latched on acceptance.
  - On acceptance with cmd_len = 0: stay in IDLE and pulse done the next cycle.
- Address arithmetic:
  - Element i uses cache address (base + i) mod 2^11 and memory address (base + i) mod 2^ADDR_W.
  - Wrap-around is silent.
- LOAD:
  - mem_req_valid = 1, mem_req_we = 0 while req_cnt < len; req_cnt increments on each handshake.
  - mem_rsp_valid in cycle t -> dma_we = 1 in cycle t+1, with dma_dat_w = rsp data and dma_addr = cache_base + rsp_cnt, all registered.
  - dma_re stays 0.
  - When the len-th response is captured: final dma_we, done = 1 and FSM = IDLE all in the same cycle t+1.
- STORE:
  - dma_re = 1 when rd_cnt < len and (fifo_occ + inflight - pop) < 2.
    - inflight = dma_re in the previous cycle.
    - pop = mem_req handshake this cycle.
  - This credit rule sustains 1 element/cycle with mem_req_ready held high.
  - dma_dat_r is captured into a 2-entry FIFO the cycle after dma_re. The FIFO never overflows.
  - mem_req_valid = FIFO non-empty, with mem_req_we = 1, mem_req_dat_w = FIFO head, mem_req_addr = mem_base + wr_cnt.
  - Request fields hold stable while valid & !ready.
  - After the len-th write handshake in cycle t: done = 1 in cycle t+1 and FSM = IDLE.
  - mem_rsp_valid is ignored in STORE and IDLE.
- Latency (store): command accepted at edge e0 -> first dma_re in cycle e0+1 -> FIFO capture at e0+2 -> first mem_req_valid in cycle e0+2 (after the e0+2 edge).
- Ordering:
  - A new command may be accepted in the done cycle.
  - Its first dcache access falls strictly after the previous command's final dma_we.
- dma_we and dma_re are never high in the same cycle.

Test Plan:
- Load, len = 4, cache base 0x10, mem base 0x100, memory with 2-cycle latency returning 0xA,0xB,0xC,0xD -> dma_we at addresses 0x10..0x13 with those data; done pulses once, with the last write.
- Store, len = 16, slot 2, mem_req_ready held 1, cache preloaded with 0..15 -> 16 consecutive cycles of write handshakes; addr base..base+15, data 0..15; done 1 cycle after the last handshake.
- Store, len = 8, mem_req_ready toggling 1,0,0,1,... -> no data lost or duplicated, FIFO occupancy never exceeds 2, request fields stable while stalled.
- Wrap-around: load with cache base 0x7FE, len = 4 -> dma_addr 0x7FE, 0x7FF, 0x000, 0x001. Store with mem base 2^24-2 -> mem_req_addr wraps the same way.
- cmd_len = 0 -> done pulses one cycle after acceptance, busy never goes high, no dma_* or mem_req activity.
- rst_n asserted mid-store after 3 of 8 writes -> all outputs 0 and cmd_ready = 1 immediately (asynchronously), no done pulse. A new load then completes normally.
